// File: rtl/krnl_vmul_hls_dl_pkg.sv
// Shared types and helpers for the HLS deadlock report unit.
//   state_t   : collector FSM states
//   id_width  : bits needed for a process id (at least 1)
//   ST_*      : bit positions inside report_status
package krnl_vmul_hls_dl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACE  = 2'd1,
    REPORT = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam int ST_ABORTED  = 0;
  localparam int ST_OVERFLOW = 1;
  localparam int ST_MULTI    = 2;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/krnl_vmul_hls_dl_prio_enc.sv
// Lowest-index priority encoder; purely combinational, no backpressure.
//   req   in  N  request vector
//   found out 1  any request bit set
//   index out W  index of the lowest set bit (0 when none)
module krnl_vmul_hls_dl_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] index
);

  // Scanning from the top down lets the lowest set bit overwrite the rest.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        index = W'(i);
      end
    end
  end

endmodule

// File: rtl/krnl_vmul_hls_deadlock_report_unit.sv
// Collects per-process deadlock detects, traces the token around the cycle and
// presents one latched report. Detect -> origin pulse / global flag: 1 cycle.
// The report record is held stable until report_valid & report_ready.
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   dl_detect_vec             detect flags from the per-process units
//   token_active_vec          per-process "token held" flags
//   dl_detect_global          broadcast detect flag back to all units
//   origin_vec                one-hot 1-cycle pulse to the origin unit
//   token_clear               combinational clear when the token returns to origin
//   deadlock                  sticky deadlock indicator
//   report_valid/ready        report handshake
//   report_origin/len/path/timestamp/status  latched report record
module krnl_vmul_hls_deadlock_report_unit
  import krnl_vmul_hls_dl_pkg::*;
#(
  parameter int PROC_NUM    = 4,
  parameter int TRACE_DEPTH = 8,
  parameter int TS_W        = 32,
  parameter int TIMEOUT     = 256,
  localparam int ID_W       = id_width(PROC_NUM),
  localparam int LEN_W      = $clog2(TRACE_DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [PROC_NUM-1:0]       dl_detect_vec,
  input  logic [PROC_NUM-1:0]       token_active_vec,
  output logic                      dl_detect_global,
  output logic [PROC_NUM-1:0]       origin_vec,
  output logic                      token_clear,
  output logic                      deadlock,
  output logic                      report_valid,
  input  logic                      report_ready,
  output logic [ID_W-1:0]           report_origin,
  output logic [LEN_W-1:0]          report_len,
  output logic [TRACE_DEPTH*ID_W-1:0] report_path,
  output logic [TS_W-1:0]           report_timestamp,
  output logic [2:0]                report_status
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [TS_W-1:0]    ts;
  logic [CNT_W-1:0]   idle_cnt;
  logic               det_found, tok_found;
  logic [ID_W-1:0]    det_idx, tok_idx;
  logic               timeout_hit;
  logic               multi_hop;

  krnl_vmul_hls_dl_prio_enc #(.N(PROC_NUM), .W(ID_W)) u_det_enc (
    .req   (dl_detect_vec),
    .found (det_found),
    .index (det_idx)
  );

  krnl_vmul_hls_dl_prio_enc #(.N(PROC_NUM), .W(ID_W)) u_tok_enc (
    .req   (token_active_vec),
    .found (tok_found),
    .index (tok_idx)
  );

  // The token has come back round: the origin sees it and re-detects.
  assign token_clear = (state == TRACE) & dl_detect_vec[report_origin]
                     & token_active_vec[report_origin];

  // This idle cycle would be the TIMEOUT-th consecutive one without a token.
  assign timeout_hit = (state == TRACE) && !tok_found
                     && (idle_cnt == CNT_W'(TIMEOUT - 1));

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign multi_hop = (token_active_vec & (token_active_vec - PROC_NUM'(1))) != '0;

  assign report_valid = (state == REPORT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (det_found)                   state_nxt = TRACE;
      TRACE:   if (token_clear || timeout_hit)  state_nxt = REPORT;
      REPORT:  if (report_ready)                state_nxt = HALT;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts               <= '0;
      idle_cnt         <= '0;
      dl_detect_global <= 1'b0;
      origin_vec       <= '0;
      deadlock         <= 1'b0;
      report_origin    <= '0;
      report_len       <= '0;
      report_path      <= '0;
      report_timestamp <= '0;
      report_status    <= '0;
    end else begin
      ts         <= ts + TS_W'(1);
      origin_vec <= '0;
      case (state)
        IDLE: begin
          if (det_found) begin
            report_origin    <= det_idx;
            report_timestamp <= ts;
            origin_vec       <= PROC_NUM'(1) << det_idx;
            dl_detect_global <= 1'b1;
            deadlock         <= 1'b1;
            idle_cnt         <= '0;
          end
        end
        TRACE: begin
          if (tok_found) begin
            idle_cnt <= '0;
            if (report_len < LEN_W'(TRACE_DEPTH)) begin
              report_path[report_len*ID_W +: ID_W] <= tok_idx;
              report_len <= report_len + LEN_W'(1);
            end else begin
              report_status[ST_OVERFLOW] <= 1'b1;
            end
            if (multi_hop) report_status[ST_MULTI] <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
            if (timeout_hit) report_status[ST_ABORTED] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_krnl_vmul_hls_deadlock_report_unit.sv
module tb_krnl_vmul_hls_deadlock_report_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  dl_detect_vec = '0;
  logic [3:0]  token_active_vec = '0;
  logic        report_ready = 1'b0;
  logic        dl_detect_global;
  logic [3:0]  origin_vec;
  logic        token_clear;
  logic        deadlock;
  logic        report_valid;
  logic [1:0]  report_origin;
  logic [3:0]  report_len;
  logic [15:0] report_path;
  logic [31:0] report_timestamp;
  logic [2:0]  report_status;

  krnl_vmul_hls_deadlock_report_unit #(
    .PROC_NUM(4), .TRACE_DEPTH(8), .TS_W(32), .TIMEOUT(256)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .dl_detect_vec    (dl_detect_vec),
    .token_active_vec (token_active_vec),
    .dl_detect_global (dl_detect_global),
    .origin_vec       (origin_vec),
    .token_clear      (token_clear),
    .deadlock         (deadlock),
    .report_valid     (report_valid),
    .report_ready     (report_ready),
    .report_origin    (report_origin),
    .report_len       (report_len),
    .report_path      (report_path),
    .report_timestamp (report_timestamp),
    .report_status    (report_status)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference cycle counter: value equals the timestamp the DUT should latch
  // when a detect is driven just after a rising edge.
  logic [31:0] cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  typedef struct {
    logic [1:0]  origin;
    logic [3:0]  len;
    logic [15:0] path;
    logic [31:0] ts;
    logic [2:0]  status;
  } rec_t;

  rec_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted report is compared against the next expected record.
  initial begin
    rec_t e;
    forever begin
      @(negedge clock);
      if (report_valid === 1'b1 && report_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_report: got origin %0d len %0d, expected none",
                   report_origin, report_len);
        end else begin
          e = exp_q.pop_front();
          chk("rpt_origin", 64'(report_origin), 64'(e.origin));
          chk("rpt_len", 64'(report_len), 64'(e.len));
          chk("rpt_path", 64'(report_path), 64'(e.path));
          chk("rpt_timestamp", 64'(report_timestamp), 64'(e.ts));
          chk("rpt_status", 64'(report_status), 64'(e.status));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dl_detect_vec = '0;
    token_active_vec = '0;
    report_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    step();
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending reports, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  logic [31:0] t_det;
  logic [3:0]  tok4 [10];

  initial begin
    tok4 = '{4'b0110, 4'b1000, 4'b0100, 4'b0010, 4'b1000,
             4'b0100, 4'b0010, 4'b1000, 4'b0100, 4'b0001};

    // Reset state
    do_reset();
    chk("rst_dl_global", 64'(dl_detect_global), 64'd0);
    chk("rst_deadlock", 64'(deadlock), 64'd0);
    chk("rst_valid", 64'(report_valid), 64'd0);
    chk("rst_origin_vec", 64'(origin_vec), 64'd0);
    chk("rst_len", 64'(report_len), 64'd0);
    step();

    // Detect on process 2
    dl_detect_vec = 4'b0100;
    t_det = cyc;
    step();
    dl_detect_vec = 4'b0000;
    chk("det_origin_vec", 64'(origin_vec), 64'b0100);
    chk("det_dl_global", 64'(dl_detect_global), 64'd1);
    chk("det_deadlock", 64'(deadlock), 64'd1);
    chk("det_timestamp", 64'(report_timestamp), 64'(t_det));
    step();
    chk("det_origin_pulse_end", 64'(origin_vec), 64'd0);

    // Trace 0 -> 3 -> 2 back to origin
    token_active_vec = 4'b0001;
    #1 chk("trace_tc_hop0", 64'(token_clear), 64'd0);
    step();
    token_active_vec = 4'b1000;
    #1 chk("trace_tc_hop1", 64'(token_clear), 64'd0);
    step();
    token_active_vec = 4'b0100;
    dl_detect_vec = 4'b0100;
    #1 chk("trace_tc_return", 64'(token_clear), 64'd1);
    exp_q.push_back('{2'd2, 4'd3, 16'h002C, t_det, 3'b000});
    report_ready = 1'b1;
    step();
    token_active_vec = '0;
    dl_detect_vec = '0;
    #1 chk("trace_tc_after", 64'(token_clear), 64'd0);
    wait_drain(20);
    chk("halt_valid", 64'(report_valid), 64'd0);
    chk("halt_dl_global", 64'(dl_detect_global), 64'd1);
    chk("halt_deadlock", 64'(deadlock), 64'd1);
    report_ready = 1'b0;
    dl_detect_vec = 4'b0001;
    step();
    dl_detect_vec = '0;
    chk("halt_ignore_origin_vec", 64'(origin_vec), 64'd0);
    chk("halt_ignore_origin", 64'(report_origin), 64'd2);

    // Simultaneous detects: lowest index wins; later detect on 3 is ignored
    do_reset();
    dl_detect_vec = 4'b1010;
    t_det = cyc;
    step();
    dl_detect_vec = '0;
    chk("sim_origin_vec", 64'(origin_vec), 64'b0010);
    chk("sim_origin", 64'(report_origin), 64'd1);
    token_active_vec = 4'b1000;
    dl_detect_vec = 4'b1000;
    #1 chk("sim_tc_other", 64'(token_clear), 64'd0);
    step();
    chk("sim_origin_kept", 64'(report_origin), 64'd1);
    chk("sim_no_new_pulse", 64'(origin_vec), 64'd0);
    token_active_vec = 4'b0010;
    dl_detect_vec = 4'b0010;
    #1 chk("sim_tc_return", 64'(token_clear), 64'd1);
    exp_q.push_back('{2'd1, 4'd2, 16'h0007, t_det, 3'b000});
    report_ready = 1'b1;
    step();
    token_active_vec = '0;
    dl_detect_vec = '0;
    wait_drain(20);
    report_ready = 1'b0;

    // Overflow and multi-token: 10 hops, first hop has two tokens
    do_reset();
    dl_detect_vec = 4'b0001;
    t_det = cyc;
    step();
    dl_detect_vec = '0;
    exp_q.push_back('{2'd0, 4'd8, 16'hDB6D, t_det, 3'b110});
    report_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      token_active_vec = tok4[i];
      if (i == 9) dl_detect_vec = 4'b0001;
      step();
    end
    token_active_vec = '0;
    dl_detect_vec = '0;
    wait_drain(20);
    report_ready = 1'b0;

    // Timeout with ready held low for 5 cycles
    do_reset();
    dl_detect_vec = 4'b1000;
    t_det = cyc;
    step();
    dl_detect_vec = '0;
    repeat (250) step();
    chk("to_not_early", 64'(report_valid), 64'd0);
    for (int i = 0; i < 20 && report_valid !== 1'b1; i++) step();
    chk("to_valid", 64'(report_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(report_valid), 64'd1);
      chk("hold_len", 64'(report_len), 64'd0);
      chk("hold_status", 64'(report_status), 64'b001);
      chk("hold_origin", 64'(report_origin), 64'd3);
      chk("hold_timestamp", 64'(report_timestamp), 64'(t_det));
      step();
    end
    exp_q.push_back('{2'd3, 4'd0, 16'h0000, t_det, 3'b001});
    report_ready = 1'b1;
    wait_drain(5);
    chk("to_valid_after", 64'(report_valid), 64'd0);
    report_ready = 1'b0;

    // Asynchronous reset in the middle of TRACE, then a fresh detection
    do_reset();
    dl_detect_vec = 4'b0001;
    step();
    dl_detect_vec = '0;
    token_active_vec = 4'b0010;
    step();
    token_active_vec = 4'b0001;
    dl_detect_vec = 4'b0001;
    #1 chk("mid_tc_pre", 64'(token_clear), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tc", 64'(token_clear), 64'd0);
    chk("mid_rst_dl_global", 64'(dl_detect_global), 64'd0);
    chk("mid_rst_deadlock", 64'(deadlock), 64'd0);
    chk("mid_rst_len", 64'(report_len), 64'd0);
    chk("mid_rst_path", 64'(report_path), 64'd0);
    chk("mid_rst_ts", 64'(report_timestamp), 64'd0);
    chk("mid_rst_valid", 64'(report_valid), 64'd0);
    token_active_vec = '0;
    dl_detect_vec = '0;
    @(posedge clock);
    #1 reset = 1'b0;
    step();
    dl_detect_vec = 4'b0100;
    t_det = cyc;
    step();
    dl_detect_vec = '0;
    chk("post_rst_origin_vec", 64'(origin_vec), 64'b0100);
    token_active_vec = 4'b0100;
    dl_detect_vec = 4'b0100;
    exp_q.push_back('{2'd2, 4'd1, 16'h0002, t_det, 3'b000});
    report_ready = 1'b1;
    step();
    token_active_vec = '0;
    dl_detect_vec = '0;
    wait_drain(20);
    report_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
